// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator request controller and the movement FSM:
// controller state encoding, one-hot-free floor codes (001..100 = floors 1..4)
// and small helpers that turn a floor code into request-bit masks.
// -----------------------------------------------------------------------------
package elevator_pkg;

  localparam int NUM_FLOORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_TRAVEL = 2'd2,
    ST_DOOR   = 2'd3
  } state_e;

  localparam logic [2:0] FLOOR_1 = 3'b001;
  localparam logic [2:0] FLOOR_2 = 3'b010;
  localparam logic [2:0] FLOOR_3 = 3'b011;
  localparam logic [2:0] FLOOR_4 = 3'b100;

  function automatic logic floor_valid(input logic [2:0] floor);
    return (floor >= FLOOR_1) && (floor <= FLOOR_4);
  endfunction

  // Request-bit index of a floor code; only meaningful when floor_valid().
  function automatic logic [1:0] floor_idx(input logic [2:0] floor);
    return 2'(floor - 3'd1);
  endfunction

  // Request bits strictly above / strictly below floor index idx.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [1:0] idx);
    return 4'b1110 << idx;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [1:0] idx);
    return (4'b0001 << idx) - 4'd1;
  endfunction

endpackage

// File: rtl/elevator_request_ctrl_if.sv
// -----------------------------------------------------------------------------
// elevator_request_ctrl_if
// Bundle between the request controller and its environment (buttons and the
// movement FSM).
//   call_btn    [3:0] floor call buttons, bit i = floor i+1
//   cur_floor   [2:0] current floor code from the movement FSM
//   stop_go           0 = step one floor this cycle, 1 = hold
//   up_down           1 = up, 0 = down
//   door_open         door held open at the current floor
//   req_pending [3:0] latched outstanding requests
// master: environment side; slave: request controller side.
// -----------------------------------------------------------------------------
interface elevator_request_ctrl_if;

  logic [3:0] call_btn;
  logic [2:0] cur_floor;
  logic       stop_go;
  logic       up_down;
  logic       door_open;
  logic [3:0] req_pending;

  modport master (
    output call_btn, cur_floor,
    input  stop_go, up_down, door_open, req_pending
  );

  modport slave (
    input  call_btn, cur_floor,
    output stop_go, up_down, door_open, req_pending
  );

endinterface

// File: rtl/elevator_request_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_request_ctrl
// Latches floor calls and steers the movement FSM one floor at a time, keeping
// the current direction while requests lie ahead and reversing only when all
// remaining requests are behind. Opens the door when the current floor has a
// pending request.
// Ports:
//   CLK  clock, all state updates on the rising edge
//   RST  synchronous active-high reset
//   bus  elevator_request_ctrl_if.slave (call_btn, cur_floor in;
//        stop_go, up_down, door_open, req_pending out)
// -----------------------------------------------------------------------------
module elevator_request_ctrl
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,   // 2..255
  parameter int DOOR_CYCLES   = 16   // 1..255
) (
  input logic                    CLK,
  input logic                    RST,
  elevator_request_ctrl_if.slave bus
);

  // Counter is loaded with N-1 on entry so the state lasts exactly N cycles.
  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  state_e                  state_q, state_d;
  logic                    up_down_q, up_down_d;
  logic [NUM_FLOORS-1:0]   req_q, req_d;
  logic [7:0]              cnt_q, cnt_d;

  logic                    floor_ok;
  logic [1:0]              floor_i;
  logic [NUM_FLOORS-1:0]   cur_mask;
  logic [NUM_FLOORS-1:0]   ahead_mask;

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge so it is just the highest-priority branch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      up_down_q <= 1'b1;
      req_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      up_down_q <= up_down_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    up_down_d  = up_down_q;
    cnt_d      = cnt_q;
    floor_ok   = floor_valid(bus.cur_floor);
    floor_i    = floor_idx(bus.cur_floor);
    cur_mask   = floor_ok ? (4'b0001 << floor_i) : '0;
    ahead_mask = up_down_q ? above_mask(floor_i) : below_mask(floor_i);
    req_d      = req_q | bus.call_btn;

    unique case (state_q)
      ST_IDLE: begin
        // An unknown floor code freezes decisions: no move, no clear.
        if (floor_ok && (req_q != '0)) begin
          if (|(req_q & cur_mask)) begin
            state_d = ST_DOOR;
            cnt_d   = DOOR_LOAD;
            req_d   = req_d & ~cur_mask;
          end else begin
            // Current bit is clear, so a non-empty set lies ahead or behind;
            // reversing when nothing is ahead also keeps the car off the
            // end stops.
            if ((req_q & ahead_mask) == '0) begin
              up_down_d = ~up_down_q;
            end
            state_d = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        state_d = ST_TRAVEL;
        cnt_d   = TRAVEL_LOAD;
      end
      ST_TRAVEL: begin
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_DOOR: begin
        // Calls for the floor being served are absorbed while the door is open.
        req_d = req_d & ~cur_mask;
        if (cnt_q == 8'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.stop_go     = (state_q != ST_MOVE);
  assign bus.up_down     = up_down_q;
  assign bus.door_open   = (state_q == ST_DOOR);
  assign bus.req_pending = req_q;

endmodule

// File: tb/tb_elevator_request_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_request_ctrl
// Self-checking bench: the bench plays the movement FSM (cur_floor steps on
// every edge where stop_go was 0) and keeps a queue of expected stop_go pulses
// and door-open episodes, compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_elevator_request_ctrl;

  localparam int TRAVEL = 8;
  localparam int DOOR   = 16;

  typedef enum {EV_MOVE, EV_DOOR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [2:0] floor;
    logic       dir;
    int         len;
    int         gap;   // cycles since previous event start, -1 = don't care
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elevator_request_ctrl_if intf();

  elevator_request_ctrl #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(intf)
  );

  ev_t        sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cycle       = 0;
  int         prev_start  = -1;
  bit         in_door     = 1'b0;
  int         door_start  = 0;
  logic [2:0] door_floor  = '0;

  function automatic void push_move(input logic [2:0] floor, input logic dir, input int gap);
    ev_t e;
    e.kind = EV_MOVE; e.floor = floor; e.dir = dir; e.len = 0; e.gap = gap;
    sb.push_back(e);
  endfunction

  function automatic void push_door(input logic [2:0] floor, input int gap);
    ev_t e;
    e.kind = EV_DOOR; e.floor = floor; e.dir = 1'b0; e.len = DOOR; e.gap = gap;
    sb.push_back(e);
  endfunction

  task automatic handle_event(input ev_kind_e kind, input logic [2:0] floor,
                              input logic dir, input int len, input int start);
    ev_t e;
    bit  bad;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got %s floor=%0d dir=%0b len=%0d at cycle %0d, required none",
               kind.name(), floor, dir, len, start);
    end else begin
      e   = sb.pop_front();
      bad = (e.kind != kind) || (e.floor !== floor) ||
            (kind == EV_MOVE && e.dir !== dir) ||
            (kind == EV_DOOR && e.len != len) ||
            (e.gap >= 0 && (start - prev_start) != e.gap);
      if (bad) begin
        miscompares++;
        $display("FAIL event: got %s floor=%0d dir=%0b len=%0d gap=%0d, required %s floor=%0d dir=%0b len=%0d gap=%0d",
                 kind.name(), floor, dir, len, start - prev_start,
                 e.kind.name(), e.floor, e.dir, e.len, e.gap);
      end
    end
    prev_start = start;
  endtask

  // Called at the negative edge: inspect this cycle's outputs.
  task automatic observe();
    if (intf.stop_go === 1'b0)
      handle_event(EV_MOVE, intf.cur_floor, intf.up_down, 0, cycle);
    if (intf.door_open === 1'b1 && !in_door) begin
      in_door    = 1'b1;
      door_start = cycle;
      door_floor = intf.cur_floor;
    end else if (intf.door_open !== 1'b1 && in_door) begin
      in_door = 1'b0;
      handle_event(EV_DOOR, door_floor, 1'b0, cycle - door_start, door_start);
    end
  endtask

  // One clock cycle: observe, cross the edge, let the movement model react.
  task automatic step();
    logic sg, ud;
    observe();
    sg = intf.stop_go;
    ud = intf.up_down;
    @(posedge clk);
    #1;
    if (sg === 1'b0) intf.cur_floor = ud ? intf.cur_floor + 3'd1 : intf.cur_floor - 3'd1;
    @(negedge clk);
    cycle++;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL timeout: %0d expected events still outstanding after %0d cycles, required 0",
               sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic do_reset(input logic [3:0] btn);
    rst = 1'b1;
    intf.call_btn = btn;
    step();
    rst = 1'b0;
    intf.call_btn = '0;
    in_door    = 1'b0;
    prev_start = -1;
    sb.delete();
  endtask

  task automatic press(input logic [3:0] btn, input logic [3:0] exp_req);
    intf.call_btn = btn;
    step();
    intf.call_btn = '0;
    vectors++;
    if (intf.req_pending !== exp_req) begin
      miscompares++;
      $display("FAIL press_latch: req_pending=%b, required %b", intf.req_pending, exp_req);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({intf.stop_go, intf.up_down, intf.door_open, intf.req_pending} !== 7'b1100000) begin
      miscompares++;
      $display("FAIL %s: stop_go=%b up_down=%b door_open=%b req_pending=%b, required 1 1 0 0000",
               name, intf.stop_go, intf.up_down, intf.door_open, intf.req_pending);
    end
  endtask

  task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    intf.cur_floor = 3'b001;
    do_reset(4'b1111);           // buttons held through the reset edge
    check_idle_outputs("reset_state");
  endtask

  task automatic test_travel_up();
    intf.cur_floor = 3'b001;
    do_reset('0);
    press(4'b0100, 4'b0100);
    push_move(3'b001, 1'b1, -1);
    push_move(3'b010, 1'b1, TRAVEL + 2);
    push_door(3'b011, TRAVEL + 2);
    run(80);
    check_val("travel_up_floor", {1'b0, intf.cur_floor}, 4'b0011);
    check_val("travel_up_req", intf.req_pending, 4'b0000);
  endtask

  task automatic test_same_floor();
    intf.cur_floor = 3'b010;
    do_reset('0);
    press(4'b0010, 4'b0010);
    step();
    check_val("door_entry_open", {3'b0, intf.door_open}, 4'b0001);
    check_val("door_entry_clear", intf.req_pending, 4'b0000);
    push_door(3'b010, -1);
    run(40);
  endtask

  task automatic test_stop_on_way();
    intf.cur_floor = 3'b001;
    do_reset('0);
    press(4'b1000, 4'b1000);
    push_move(3'b001, 1'b1, -1);
    run(10);
    press(4'b0010, 4'b1010);     // latched during TRAVEL
    push_door(3'b010, TRAVEL + 2);
    push_move(3'b010, 1'b1, DOOR + 1);
    push_move(3'b011, 1'b1, TRAVEL + 2);
    push_door(3'b100, TRAVEL + 2);
    run(120);
    check_val("stop_on_way_floor", {1'b0, intf.cur_floor}, 4'b0100);
    check_val("stop_on_way_dir", {3'b0, intf.up_down}, 4'b0001);
    check_val("stop_on_way_req", intf.req_pending, 4'b0000);
  endtask

  task automatic test_reverse();
    intf.cur_floor = 3'b100;
    do_reset('0);
    press(4'b0001, 4'b0001);
    push_move(3'b100, 1'b0, -1);  // direction flips on the edge into MOVE
    push_move(3'b011, 1'b0, TRAVEL + 2);
    push_move(3'b010, 1'b0, TRAVEL + 2);
    push_door(3'b001, TRAVEL + 2);
    run(100);
    check_val("reverse_floor", {1'b0, intf.cur_floor}, 4'b0001);
  endtask

  task automatic test_reset_mid_travel();
    intf.cur_floor = 3'b100;
    do_reset('0);
    press(4'b0010, 4'b0010);
    push_move(3'b100, 1'b0, -1);
    run(10);
    press(4'b1000, 4'b1010);
    settle(2);
    do_reset('0);
    check_idle_outputs("reset_mid_travel");
    settle(30);                  // nothing may survive the reset
    check_val("reset_mid_travel_floor", {1'b0, intf.cur_floor}, 4'b0011);
  endtask

  task automatic test_door_absorb();
    intf.cur_floor = 3'b011;
    do_reset('0);
    push_door(3'b011, -1);
    press(4'b0100, 4'b0100);
    step();
    intf.call_btn = 4'b0100;     // held through the whole door cycle
    for (int i = 0; i < DOOR; i++) begin
      vectors++;
      if (intf.door_open !== 1'b1 || intf.req_pending !== 4'b0000) begin
        miscompares++;
        $display("FAIL door_absorb[%0d]: door_open=%b req_pending=%b, required 1 0000",
                 i, intf.door_open, intf.req_pending);
      end
      step();
    end
    intf.call_btn = '0;
    check_val("door_absorb_after", {intf.door_open, intf.req_pending[2:0]}, 4'b0000);
    run(5);
  endtask

  task automatic test_invalid_floor();
    intf.cur_floor = 3'b000;
    do_reset('0);
    intf.call_btn = 4'b0100;
    settle(50);                  // any stop_go pulse or door is unexpected
    intf.call_btn = '0;
    check_val("invalid_floor_req", intf.req_pending, 4'b0100);
    check_val("invalid_floor_stop", {3'b0, intf.stop_go}, 4'b0001);
    intf.cur_floor = 3'b011;
    push_door(3'b011, -1);
    run(40);
    check_val("invalid_floor_recover", intf.req_pending, 4'b0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    intf.call_btn  = '0;
    intf.cur_floor = 3'b001;
    test_reset();
    test_travel_up();
    test_same_floor();
    test_stop_on_way();
    test_reverse();
    test_reset_mid_travel();
    test_door_absorb();
    test_invalid_floor();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elevator_request_ctrl.md
ELEVATOR_REQUEST_CTRL -- requirements
Module: elevator_request_ctrl

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8, cycles spent in TRAVEL per floor step; legal range 2..255.
REQ-002 Parameter DOOR_CYCLES, default 16, cycles door_open is held per stop; legal range 1..255.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 call_btn  input  4  floor call buttons; bit i = floor i+1; level or pulse, sampled every cycle.
REQ-006 cur_floor  input  3  current floor from the movement FSM: 3'b001..3'b100 = floors 1..4.
REQ-007 stop_go  output  1  to movement FSM: 0 = step one floor this cycle, 1 = hold.
REQ-008 up_down  output  1  to movement FSM: 1 = up, 0 = down; registered direction.
REQ-009 door_open  output  1  high while stopped with the door open.
REQ-010 req_pending  output  4  latched outstanding requests, same bit mapping as call_btn.

Function
REQ-011 FSM states SHALL be IDLE, MOVE, TRAVEL, DOOR.
REQ-012 stop_go SHALL be 0 only in MOVE, which lasts exactly one cycle; stop_go is 1 in all other states.
REQ-013 req_pending[i] SHALL set on the edge after call_btn[i]=1 and hold until served.
REQ-014 IDLE with req_pending bit at cur_floor set SHALL go to DOOR; that bit clears on the same edge.
REQ-015 Otherwise, IDLE with a pending request strictly ahead in direction up_down SHALL go to MOVE, keeping up_down.
REQ-016 Otherwise, IDLE with a pending request only behind SHALL invert up_down and go to MOVE on the same edge.
REQ-017 IDLE with req_pending = 0 SHALL remain in IDLE with up_down unchanged.
REQ-018 MOVE SHALL go to TRAVEL; TRAVEL SHALL last exactly TRAVEL_CYCLES cycles, then return to IDLE.
REQ-019 DOOR SHALL hold door_open=1 for exactly DOOR_CYCLES cycles, then return to IDLE.
REQ-020 While in DOOR, call_btn for the current floor SHALL be absorbed: the bit is not set.
REQ-021 call_btn for any other floor SHALL latch in every state, including MOVE and TRAVEL.
REQ-022 MOVE SHALL never be entered with up_down=1 at floor 4 or up_down=0 at floor 1.
REQ-023 An invalid cur_floor value (000, 101-111) SHALL keep the FSM in IDLE: no move issued, no request cleared.
REQ-024 The cycle counter SHALL be 8 bits, load on state entry, and count down to the exit condition without wrap-around.

Reset
REQ-025 RST=1 SHALL force IDLE, stop_go=1, up_down=1, door_open=0, req_pending=0, counter=0 on the next edge.
REQ-026 RST SHALL take priority over call_btn and over reset asserted mid-MOVE, mid-TRAVEL or mid-DOOR.
REQ-027 No request SHALL survive reset.

Structure
REQ-028 FSM state encoding and the floor codes 001..100 SHALL live in shared package elevator_pkg, also used by the movement FSM.
REQ-029 The design SHALL be a single module with no sub-modules; the cycle counter is inline.

Verification
REQ-030 Test 1: reset at floor 1, call_btn=0100 for 1 cycle -> two single-cycle stop_go=0 pulses 10 cycles apart, each with up_down=1; cur_floor reaches 011; door_open high 16 cycles; req_pending returns to 0000.
REQ-031 Test 2: idle at floor 2, call_btn=0010 -> no stop_go pulse; door_open high 16 cycles; req_pending[1] clears on DOOR entry.
REQ-032 Test 3: at floor 1, press 1000; during first TRAVEL press 0010 -> stops at floor 2 first with a door cycle, then continues up to floor 4 with no direction change.
REQ-033 Test 4: at floor 4 with up_down=1, press 0001 -> up_down=0 on the same edge MOVE is entered; three down steps; door opens at floor 1.
REQ-034 Test 5: assert RST mid-TRAVEL with req_pending=1010 -> next cycle: IDLE, req_pending=0000, stop_go=1, up_down=1, door_open=0.
REQ-035 Test 6: hold call_btn of the current floor through DOOR -> bit stays 0; same with cur_floor=000 -> no stop_go pulse for 50 cycles.
